// File: rtl/edge_detect_bank.sv
// Multi-channel input conditioner: synchroniser, debounce filter, edge pulse,
// sticky pending flags with per-channel clear, and an OR-reduced interrupt.
module edge_detect_bank #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] mode_rise,
  input  logic [CHANNELS-1:0] mode_fall,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] toggle_c;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] pulse_d;
  logic [CHANNELS-1:0] pending_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after it has differed for DEBOUNCE_CYCLES samples.
  always_comb begin
    toggle_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          toggle_c[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mode is judged against the pre-toggle level: 0->1 uses rise, 1->0 uses fall.
  always_comb begin
    level_d   = level ^ toggle_c;
    pulse_d   = toggle_c & ((~level & mode_rise) | (level & mode_fall));
    pending_d = pulse_d | (pending & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level   <= '0;
      pulse   <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level   <= level_d;
      pulse   <= pulse_d;
      pending <= pending_d;
      irq     <= |pending;
    end
  end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed plus randomised checks of edge_detect_bank against a history-window
// reference model: a level flips once the last DEBOUNCE_CYCLES samples all disagree.
module tb_edge_detect_bank;
  localparam int unsigned CH = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] din, mode_rise, mode_fall, clr;
  logic [CH-1:0] level, pulse, pending;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  logic [CH-1:0] din_hist [SS+1];
  logic [CH-1:0] s_win    [DC];
  logic [CH-1:0] m_level, m_pulse, m_pending;
  logic          m_irq;

  always #5 clk = ~clk;

  edge_detect_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .din(din), .mode_rise(mode_rise), .mode_fall(mode_fall),
    .clr(clr), .level(level), .pulse(pulse), .pending(pending), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= SS; j++) din_hist[j] = '0;
    for (int j = 0; j < DC; j++) s_win[j] = '0;
    m_level = '0; m_pulse = '0; m_pending = '0; m_irq = 1'b0;
  endtask

  // One rising clock edge of the reference, using the inputs present at that edge.
  task automatic model_edge();
    logic [CH-1:0] toggle;
    m_irq = |m_pending;
    for (int j = SS; j > 0; j--) din_hist[j] = din_hist[j-1];
    din_hist[0] = din;
    for (int j = DC - 1; j > 0; j--) s_win[j] = s_win[j-1];
    s_win[0] = din_hist[SS];
    toggle = '1;
    for (int j = 0; j < DC; j++) toggle &= s_win[j] ^ m_level;
    m_pulse   = toggle & ((~m_level & mode_rise) | (m_level & mode_fall));
    m_level   = m_level ^ toggle;
    m_pending = m_pulse | (m_pending & ~clr);
  endtask

  task automatic check_all();
    chk("level",   32'(level),   32'(m_level));
    chk("pulse",   32'(pulse),   32'(m_pulse));
    chk("pending", 32'(pending), 32'(m_pending));
    chk("irq",     32'(irq),     32'(m_irq));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_all();
    clr = '1; step(); clr = '0;
  endtask

  initial begin
    int p_first, p_count;
    rst = 1'b1; din = '0; mode_rise = '1; mode_fall = '0; clr = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Step on channel 0: level/pulse at edge 6, irq one edge later.
    din = 8'h01;
    run(5);
    chk("ch0_lvl_e5", 32'(level[0]), 32'd0);
    step();
    chk("ch0_lvl_e6", 32'(level[0]), 32'd1);
    chk("ch0_pls_e6", 32'(pulse[0]), 32'd1);
    chk("ch0_irq_e6", 32'(irq), 32'd0);
    step();
    chk("ch0_pls_e7", 32'(pulse[0]), 32'd0);
    chk("ch0_pnd_e7", 32'(pending[0]), 32'd1);
    chk("ch0_irq_e7", 32'(irq), 32'd1);

    // Three-cycle glitch on channel 3 must be rejected.
    din[3] = 1'b1;
    run(3);
    din[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch3", 32'({level[3], pulse[3], pending[3]}), 32'd0);
    end

    // Channel 1 both edges, then rise only.
    mode_fall[1] = 1'b1;
    p_first = -1; p_count = 0;
    din[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 20) din[1] = 1'b0;
      step();
      if (pulse[1]) begin
        if (p_first < 0) p_first = k; else chk("ch1_gap", 32'(k - p_first), 32'd20);
        p_count++;
      end
    end
    chk("ch1_both_cnt", 32'(p_count), 32'd2);
    mode_fall[1] = 1'b0;
    p_count = 0;
    din[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 20) din[1] = 1'b0;
      step();
      if (pulse[1]) p_count++;
    end
    chk("ch1_rise_cnt", 32'(p_count), 32'd1);

    // Set beats clear on channel 2, then a lone clear drops it.
    clear_all();
    mode_fall[2] = 1'b1;
    din[2] = 1'b1;
    run(6);
    chk("ch2_pnd_set", 32'(pending[2]), 32'd1);
    din[2] = 1'b0;
    run(5);
    clr[2] = 1'b1;
    step();
    chk("ch2_pls_clr", 32'(pulse[2]), 32'd1);
    chk("ch2_pnd_prio", 32'(pending[2]), 32'd1);
    step();
    chk("ch2_pnd_clr", 32'(pending[2]), 32'd0);
    chk("ch2_irq_lag", 32'(irq), 32'd1);
    clr[2] = 1'b0;
    step();
    chk("ch2_irq_low", 32'(irq), 32'd0);

    // Simultaneous rising edges on A5.
    din = '0;
    run(10);
    clear_all();
    mode_rise = '1; mode_fall = '0;
    din = 8'hA5;
    run(5);
    chk("a5_pls_early", 32'(pulse), 32'd0);
    step();
    chk("a5_pulse", 32'(pulse), 32'hA5);
    chk("a5_pending", 32'(pending), 32'hA5);

    // Reset with channel 4 two counts into its debounce window.
    din = 8'hB5;
    run(4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 rst = 1'b0;
    run(5);
    chk("ch4_lvl_rel5", 32'(level[4]), 32'd0);
    step();
    chk("ch4_lvl_rel6", 32'(level[4]), 32'd1);

    // Randomised: slowly toggling inputs, occasional mode and clear activity.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(5, 0) == 0) din[i] = ~din[i];
      end
      if ($urandom_range(15, 0) == 0) begin
        mode_rise = CH'($urandom);
        mode_fall = CH'($urandom);
      end
      clr = ($urandom_range(7, 0) == 0) ? CH'($urandom) : '0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_detect_bank.md
Name: edge_detect_bank

Overview:
- Multi-channel, parametrised edge detector for PicoBlaze-attached pushbuttons and switches.
- Each channel synchronises an asynchronous input, debounces it and detects rising and/or falling edges under per-channel mode control.
- Each detected edge produces a one-clock pulse and sets a sticky pending flag. Firmware clears pending flags through a per-channel clear strobe.
- All pending flags are OR-reduced into a single interrupt request.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (2..4).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new level must hold before acceptance (1..65535). A value of 1 gives no filtering beyond one sample.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  CHANNELS  raw asynchronous channel inputs.
- mode_rise  input  CHANNELS  per-channel enable for rising-edge detection.
- mode_fall  input  CHANNELS  per-channel enable for falling-edge detection.
- clr  input  CHANNELS  per-channel synchronous clear of pending; one-cycle strobe or level.
- level  output  CHANNELS  debounced, synchronised level of each channel.
- pulse  output  CHANNELS  one-clock strobe per accepted, enabled edge.
- pending  output  CHANNELS  sticky edge-seen flags.
- irq  output  1  OR of all pending bits.

Behaviour:
- Reset: all synchroniser flops, debounce counters, level, pulse and pending go to 0; irq = 0.
  - Reset is asynchronous on assertion and takes effect mid-operation: all in-flight counts are discarded.
- Synchroniser: din[i] passes through SYNC_STAGES flops; the output of the last flop is s[i].
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES)+1.
  - If s[i] == level[i], the counter is cleared to 0.
  - If s[i] != level[i] and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s[i] != level[i] and counter == DEBOUNCE_CYCLES-1, level[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles never changes level.
- Latency: for a din step captured at edge 1, level changes after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
- Edge pulse: registered and asserted on the same clock edge as the level toggle. Duration is exactly one cycle.
  - 0->1 toggle: pulse[i] = mode_rise[i].
  - 1->0 toggle: pulse[i] = mode_fall[i].
  - Mode inputs are sampled at the toggle edge. Changing a mode never creates or suppresses an edge retroactively.
- Pending: set when the registered pulse condition is true, i.e. on the same edge pulse rises.
  - Cleared when clr[i] is high.
  - Set has priority over clear when both occur at the same edge; pending stays 1.
  - A held clr keeps pending at 0, except on edges that set it.
- irq: registered OR of pending; updates one cycle after pending.
- Input high through reset release: level starts at 0, so a rising edge is accepted after full latency. Pulse and pending follow only if mode_rise is set.
- Channels are fully independent; simultaneous edges on several channels all pulse in the same cycle.
- Counter never wraps: it saturates by construction at DEBOUNCE_CYCLES-1 before clearing.

Test Plan:
- Defaults, mode_rise=FF, mode_fall=00: step din[0] 0->1 captured at edge 1 and held -> level[0]=1 and pulse[0]=1 for exactly one cycle after edge 6. Then pending[0]=1, and irq=1 after edge 7.
- din[3] high for 3 cycles then low (a glitch shorter than DEBOUNCE_CYCLES=4) -> level, pulse and pending[3] stay 0 throughout.
- mode_rise[1]=mode_fall[1]=1: din[1] high 20 cycles, then low -> two single-cycle pulses on channel 1, 20 cycles apart. mode_fall=0 instead -> only the first pulse.
- pending[2]=1; assert clr[2] on the same edge a new pulse[2] occurs -> pending[2] stays 1. Assert clr[2] alone next cycle -> pending[2]=0 and irq=0 one cycle later.
- din=8'hA5 applied simultaneously, all modes rise -> pulse=8'hA5 in a single cycle, pending=8'hA5.
- Assert rst while channel 4 has counted 2 of 4 debounce cycles -> all outputs 0 immediately. With din[4] still high after release -> level[4] rises 6 edges after the release.
